// File: rtl/ps2_event_pkg.sv
// Shared types and helpers for the PS/2 event collector.
// Optional timestamp field is present only when PS2_EVENT_TS_EN is defined.
package ps2_event_pkg;

    localparam int unsigned CODE_W   = 8;
    localparam int unsigned CH_MAX_W = 3;
    localparam int unsigned TS_MAX_W = 32;

    // Field widths are sized for the largest legal configuration; narrower builds slice them.
    typedef struct packed {
        logic [CODE_W-1:0]   code;
        logic [CH_MAX_W-1:0] ch;
        logic                err;
`ifdef PS2_EVENT_TS_EN
        logic [TS_MAX_W-1:0] ts;
`endif
    } ps2_event_t;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the search origin
// advances to the channel after the last grant and holds when idle.
module rr_arbiter
    import ps2_event_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = ch_width(N)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;
    logic             found;
    int unsigned      k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k   = (32'(ptr_q) + i) % N;
            idx = IDX_W'(k);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_event_fifo.sv
// Multi-channel PS/2 byte collector: per-channel pending slots, round-robin
// merge into a shared event FIFO, sticky overflow flags. Option: PS2_EVENT_TS_EN.
module ps2_event_fifo
    import ps2_event_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned TS_W   = 16,
    localparam int unsigned CH_W   = ch_width(NUM_CH),
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CNT_W  = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic [CODE_W*NUM_CH-1:0] code_i,
    input  logic [NUM_CH-1:0]        strobe_i,
    input  logic [NUM_CH-1:0]        err_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [CODE_W-1:0]        rd_code_o,
    output logic [CH_W-1:0]          rd_ch_o,
    output logic                     rd_err_o,
`ifdef PS2_EVENT_TS_EN
    output logic [TS_W-1:0]          rd_ts_o,
`endif
    output logic [CNT_W-1:0]         count_o,
    output logic [NUM_CH-1:0]        overflow_o,
    input  logic [NUM_CH-1:0]        ovf_clr_i
);

    ps2_event_t        slot_q  [NUM_CH];
    ps2_event_t        new_ev  [NUM_CH];
    logic [NUM_CH-1:0] slot_vld_q;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;

    ps2_event_t        mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [NUM_CH-1:0] ovf_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    ps2_event_t        head;

`ifdef PS2_EVENT_TS_EN
    logic [TS_W-1:0]   ts_cnt_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            new_ev[c]      = '0;
            new_ev[c].code = code_i[CODE_W*c +: CODE_W];
            new_ev[c].ch   = CH_MAX_W'(c);
            new_ev[c].err  = err_i[c];
`ifdef PS2_EVENT_TS_EN
            new_ev[c].ts   = TS_MAX_W'(ts_cnt_q);
`endif
            drop[c]        = strobe_i[c] && slot_vld_q[c] && !gnt[c];
        end
    end

    // A granted slot may be refilled in the same cycle it is emptied.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            slot_vld_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (strobe_i[c] && (!slot_vld_q[c] || gnt[c])) begin
                    slot_vld_q[c] <= 1'b1;
                    slot_q[c]     <= new_ev[c];
                end else if (gnt[c]) begin
                    slot_vld_q[c] <= 1'b0;
                end
            end
        end
    end

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && rd_ready_i;
    assign push  = |gnt;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .reset_i (reset_i),
        .req     (slot_vld_q),
        .en      (!full || pop),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= slot_q[gnt_idx];
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            ovf_q <= (ovf_q & ~ovf_clr_i) | drop;
        end
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_valid_o = !empty;
    assign rd_code_o  = head.code;
    assign rd_ch_o    = head.ch[CH_W-1:0];
    assign rd_err_o   = head.err;
`ifdef PS2_EVENT_TS_EN
    assign rd_ts_o    = head.ts[TS_W-1:0];
`endif
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // Upper field bits exist only to fit the widest configuration.
    logic unused_head_bits;
`ifdef PS2_EVENT_TS_EN
    assign unused_head_bits = ^{head.ch, head.ts};
`else
    assign unused_head_bits = ^head.ch;
`endif

endmodule

// File: doc/ps2_event_fifo.md
# ps2_event_fifo

Parametrised multi-channel PS/2 byte collector that sits between the PS/2 receivers (keyboard, mouse, further ports) and the SoC peripheral bus. Each channel delivers scan-code bytes as `code`/`strobe`/`err` triples, the same form the keyboard path uses today. The block arbitrates the channels round-robin into one shared event FIFO, tags each entry with its channel and error status, and keeps sticky per-channel overflow flags. It generalises the single-keyboard path to `NUM_CH` channels with buffered, back-pressured readout.

## Interface
Parameters:
- `NUM_CH`, 2: number of PS/2 input channels; legal range 1..8.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TS_W`, 16: timestamp width; used only when `PS2_EVENT_TS_EN` is defined.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock for the whole block.
- `reset_i`  in  1  asynchronous, active-high reset.
- `code_i`  in  8*NUM_CH  channel c byte at [8c+7:8c].
- `strobe_i`  in  NUM_CH  one-cycle pulse per received byte.
- `err_i`  in  NUM_CH  frame/parity error; qualified by strobe.
- `rd_valid_o`  out  1  FIFO head valid.
- `rd_ready_i`  in  1  consumer pops the head when `rd_valid_o` is also high.
- `rd_code_o`  out  8  head byte.
- `rd_ch_o`  out  CH_W  head channel, where CH_W = max(1, $clog2(NUM_CH)).
- `rd_err_o`  out  1  head error bit.
- `rd_ts_o`  out  TS_W  head timestamp; port exists only with `PS2_EVENT_TS_EN`.
- `count_o`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow_o`  out  NUM_CH  sticky drop flag per channel.
- `ovf_clr_i`  in  NUM_CH  clears the matching overflow bit.

## Operation
- **Pending slot per channel:** each channel has one slot (valid, code, err, ts). A strobe loads the slot when the slot is empty, or when the slot is being granted in the same cycle.
- **Dropped bytes:** a strobe that arrives while the slot is full and not granted is discarded. The channel's `overflow_o` bit is set.
- **Arbiter:** a round-robin arbiter grants at most one pending channel per cycle. A grant happens only if the FIFO has space, meaning `count_o` < DEPTH, or the FIFO is full and a pop occurs in the same cycle.
- **Grant effect:** the granted slot is written into the FIFO and cleared.
- **Priority rotation:** after a grant to channel c, search starts at (c+1) mod NUM_CH. The priority pointer is unchanged when no grant occurs.
- **FIFO pointers:** read and write pointers are $clog2(DEPTH) bits plus a wrap bit. Full is reached when the addresses are equal and the wrap bits differ. Empty is reached when the pointers are equal.
- **Pop:** fires on `rd_valid_o && rd_ready_i`. A pop when empty is impossible because `rd_valid_o` is 0.
- **Head outputs:** `rd_*` outputs show the head entry directly. They hold stable while `rd_valid_o`=1 and `rd_ready_i`=0.
- **Overflow flag priority:** a set event and `ovf_clr_i` in the same cycle leave the bit at 1.
- **Reset effects:**
  - All outputs go to 0.
  - All slots empty, FIFO empty, storage zeroed.
  - Arbiter pointer = 0.
  - Timestamp counter = 0.
- **Reset mid-operation:** pending and queued bytes are lost. No partial entry survives.

## Timing
- A strobe at cycle N loads the slot at the edge ending N.
- The earliest grant is in cycle N+1. `rd_valid_o` rises in cycle N+2, so minimum latency is 2 cycles.
- Sustained throughput is one entry per cycle across all channels.
- All channels strobing in the same cycle drain in round-robin order over NUM_CH cycles.
- Full FIFO with a pop in the same cycle: the push is accepted and `count_o` is unchanged.
- Push without pop gives `count_o`+1. Pop without push gives `count_o`−1.
- `count_o` and `overflow_o` are registered and update at the edge after the event.

## Configuration
- `PS2_EVENT_TS_EN` defined:
  - A free-running TS_W-bit counter counts from reset and wraps modulo 2^TS_W.
  - Its value is captured into the pending slot on the accepted strobe, stored per FIFO entry, and presented on `rd_ts_o`.
- Undefined: no counter, no timestamp storage, and no `rd_ts_o` port.

## Structure
- Package `ps2_event_pkg` holds:
  - `CODE_W` = 8.
  - The `ps2_event_t` struct (code, ch, err, and ts under the macro).
  - A function computing CH_W.
- Sub-module `rr_arbiter`, parametrised by N: inputs are request vector and enable; outputs are one-hot grant and grant index. It contains the rotating pointer.
- FIFO storage is inferred RAM/registers inside the top-level `ps2_event_fifo`.

## Test plan
- **Single byte, no back-pressure:** channel 0 strobes 0x1C with err=0 at cycle 5, `rd_ready_i`=1. Expect `rd_valid_o`=1 at cycle 7 with code 0x1C, ch 0, err 0, and `count_o` back to 0 after the pop.
- **Round-robin order:** NUM_CH=2, both channels strobe in the same cycle (0x11 on ch0, 0x22 on ch1), then strobe again (0x33, 0x44). Expect FIFO order ch0 0x11, ch1 0x22, ch0 0x33, ch1 0x44.
- **Full FIFO:** `rd_ready_i`=0 and DEPTH+1 bytes arrive on ch1 at 1 per 2 cycles. Expect `count_o`=16 and the 17th byte held in the slot. A further strobe sets `overflow_o[1]` while `overflow_o[0]` stays 0. Raising `rd_ready_i` delivers the held 17th byte, not the dropped one.
- **Overflow flag priority:** `ovf_clr_i[1]` coincides with a new drop on ch1. Expect `overflow_o[1]` to stay 1. Clearing on a later, drop-free cycle returns it to 0.
- **Error tagging:** ch1 strobes 0xF0 with err=1. Expect `rd_err_o`=1 and `rd_ch_o`=1 for that entry.
- **Reset mid-operation:** assert `reset_i` asynchronously while 5 entries are queued. Expect all outputs at 0 immediately and no entries after release. With `PS2_EVENT_TS_EN`, the first post-reset timestamp equals the cycles elapsed since release.
